// File: rtl/register_bank_param.sv
// register_bank_param: parameterised two-read / one-write register bank.
// After reset an INIT sweep writes reg[i] = i into every entry. The bank
// then enters RUN, where it accepts writes and serves combinational reads.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a write
// being performed this cycle is forwarded straight to any read port whose
// address matches.
module register_bank_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] rw,
  input  logic [DATA_W-1:0] busw,
  output logic [DATA_W-1:0] busa,
  output logic [DATA_W-1:0] busb,
  output logic              ready
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int WIDE_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } stateT;

  stateT               r_state;
  stateT               w_stateNext;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cntNext;
  logic                w_ready;
  logic                w_zeroDiscard;
  logic                w_runWrite;
  logic                w_we;
  logic [ADDR_W-1:0]   w_wAddr;
  logic [DATA_W-1:0]   w_wData;
  logic [WIDE_W-1:0]   w_cntWide;
  logic [DATA_W-1:0]   w_aRaw;
  logic [DATA_W-1:0]   w_bRaw;
  logic [DATA_W-1:0]   r_bank [DEPTH];

  // The sweep value is the counter, zero-extended or truncated to DATA_W.
  assign w_cntWide = WIDE_W'(r_cnt);

  // A write to address 0 is dropped when register 0 is hardwired to zero.
  assign w_zeroDiscard = (ZERO_REG != 0) && (rw == '0);
  assign w_runWrite    = (r_state == ST_RUN) && reg_write && !w_zeroDiscard;

  // State and sweep-counter register; reset restarts the sweep from 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Next-state logic: INIT steps through every address once, then RUN.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_ready     = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_cntNext = r_cnt + 1'b1;
        if (r_cnt == '1) begin
          w_stateNext = ST_RUN;
        end
      end
      ST_RUN: begin
        w_ready = 1'b1;
      end
      default: begin
        w_stateNext = ST_INIT;
      end
    endcase
  end

  assign ready = w_ready;

  // Write-port mux: reset clears reg[0], INIT writes the sweep, RUN takes user writes.
  always_comb begin
    w_we    = 1'b0;
    w_wAddr = r_cnt;
    w_wData = w_cntWide[DATA_W-1:0];
    if (reset) begin
      w_we    = 1'b1;
      w_wAddr = '0;
      w_wData = '0;
    end else if (r_state == ST_INIT) begin
      w_we = 1'b1;
    end else if (w_runWrite) begin
      w_we    = 1'b1;
      w_wAddr = rw;
      w_wData = busw;
    end
  end

  // Storage array: single write port, committed on the rising edge.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_bank[w_wAddr] <= w_wData;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_fwdEn;

  // A write that is taken this cycle (reset not cancelling it) is forwarded.
  assign w_fwdEn = w_runWrite && !reset;

  // Raw read data, with the in-flight write forwarded on an address match.
  always_comb begin
    w_aRaw = r_bank[ra];
    w_bRaw = r_bank[rb];
    if (w_fwdEn && (rw == ra)) begin
      w_aRaw = busw;
    end
    if (w_fwdEn && (rw == rb)) begin
      w_bRaw = busw;
    end
  end
`else
  // Raw read data straight from the array; a write shows after its edge.
  always_comb begin
    w_aRaw = r_bank[ra];
    w_bRaw = r_bank[rb];
  end
`endif

  // Read ports return 0 during INIT and for a hardwired register 0.
  always_comb begin
    busa = w_aRaw;
    busb = w_bRaw;
    if ((r_state == ST_INIT) || ((ZERO_REG != 0) && (ra == '0))) begin
      busa = '0;
    end
    if ((r_state == ST_INIT) || ((ZERO_REG != 0) && (rb == '0))) begin
      busb = '0;
    end
  end

endmodule

// File: tb/tb_register_bank_param.sv
// tb_register_bank_param: directed bench for register_bank_param.
// Three instances share the stimulus: the default build, one with
// ZERO_REG=0, and a narrow one with DATA_W=4. Expected values go into a
// scoreboard queue and are popped when the outputs are sampled.
module tb_register_bank_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrite;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [4:0]  rw;
  logic [31:0] busw;
  logic [31:0] busa;
  logic [31:0] busb;
  logic        ready;
  logic [31:0] busaZ;
  logic [31:0] busbZ;
  logic        readyZ;
  logic [3:0]  busaN;
  logic [3:0]  busbN;
  logic        readyN;

  int assertCount = 0;
  int failCount   = 0;

  localparam int SRC_BUSA   = 0;
  localparam int SRC_BUSB   = 1;
  localparam int SRC_READY  = 2;
  localparam int SRC_Z_BUSA = 3;
  localparam int SRC_N_BUSA = 4;
  localparam int SRC_N_BUSB = 5;
  localparam int SRC_Z_RDY  = 6;
  localparam int SRC_N_RDY  = 7;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    string       tag;
    int          src;
    logic [31:0] exp;
  } expT;

  expT sbQ[$];

  register_bank_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .reg_write(regWrite), .ra(ra), .rb(rb), .rw(rw),
    .busw(busw), .busa(busa), .busb(busb), .ready(ready)
  );

  register_bank_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dutZ (
    .clk(clk), .reset(reset), .reg_write(regWrite), .ra(ra), .rb(rb), .rw(rw),
    .busw(busw), .busa(busaZ), .busb(busbZ), .ready(readyZ)
  );

  register_bank_param #(.DATA_W(4), .ADDR_W(5), .ZERO_REG(1)) dutN (
    .clk(clk), .reset(reset), .reg_write(regWrite), .ra(ra), .rb(rb), .rw(rw),
    .busw(busw[3:0]), .busa(busaN), .busb(busbN), .ready(readyN)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Current value of the output selected by src, zero-extended to 32 bits.
  function automatic logic [31:0] observe(int src);
    case (src)
      SRC_BUSA:   return busa;
      SRC_BUSB:   return busb;
      SRC_READY:  return {31'd0, ready};
      SRC_Z_BUSA: return busaZ;
      SRC_N_BUSA: return {28'd0, busaN};
      SRC_N_BUSB: return {28'd0, busbN};
      SRC_Z_RDY:  return {31'd0, readyZ};
      SRC_N_RDY:  return {31'd0, readyN};
      default:    return 32'hXXXX_XXXX;
    endcase
  endfunction

  // Queue one expected result for the next sampling point.
  task automatic applyStimulus(input string tag, input int src, input logic [31:0] exp);
    expT e;
    e.tag = tag;
    e.src = src;
    e.exp = exp;
    sbQ.push_back(e);
  endtask

  // Let the combinational outputs settle, then drain the scoreboard.
  task automatic checkOutput();
    expT         e;
    logic [31:0] obs;
    #1;
    while (sbQ.size() > 0) begin
      e   = sbQ.pop_front();
      obs = observe(e.src);
      assertCount++;
      assert (obs === e.exp) else begin
        failCount++;
        $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Advance one rising edge and move 1 time unit past it before driving.
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    regWrite = 1'b0;
    ra       = 5'd7;
    rb       = 5'd0;
    rw       = 5'd0;
    busw     = 32'd0;

    // Reset state: one reset edge, then release.
    stepClk();
    reset = 1'b0;
    applyStimulus("reset_ready", SRC_READY, 32'd0);
    applyStimulus("reset_busa",  SRC_BUSA,  32'd0);
    checkOutput();

    // Sweep with a write held active; the write must be ignored and reads stay 0.
    ra       = 5'd5;
    regWrite = 1'b1;
    rw       = 5'd5;
    busw     = 32'h1234_5678;
    for (int k = 1; k <= 32; k++) begin
      stepClk();
      if (k == 32) begin
        regWrite = 1'b0;
      end
      applyStimulus($sformatf("init_ready_%0d", k), SRC_READY, (k == 32) ? 32'd1 : 32'd0);
      if (k < 32) begin
        applyStimulus($sformatf("init_busa_%0d", k), SRC_BUSA, 32'd0);
      end
      checkOutput();
    end
    applyStimulus("ready_z", SRC_Z_RDY, 32'd1);
    applyStimulus("ready_n", SRC_N_RDY, 32'd1);
    checkOutput();

    // Sweep contents and read ports after init.
    ra = 5'd7;
    rb = 5'd9;
    applyStimulus("read_a7", SRC_BUSA, 32'h0000_0007);
    applyStimulus("read_b9", SRC_BUSB, 32'h0000_0009);
    checkOutput();
    ra = 5'd31;
    rb = 5'd0;
    applyStimulus("read_a31", SRC_BUSA, 32'h0000_001F);
    applyStimulus("read_b0",  SRC_BUSB, 32'h0000_0000);
    checkOutput();
    ra = 5'd5;
    applyStimulus("init_write_ignored", SRC_BUSA, 32'h0000_0005);
    checkOutput();
    ra = 5'd17;
    rb = 5'd17;
    applyStimulus("narrow_a17", SRC_N_BUSA, 32'h1);
    applyStimulus("narrow_b17", SRC_N_BUSB, 32'h1);
    applyStimulus("same_addr_a", SRC_BUSA, 32'd17);
    applyStimulus("same_addr_b", SRC_BUSB, 32'd17);
    checkOutput();

    // Write reg 3; forwarding decides the same-cycle value.
    ra       = 5'd3;
    rb       = 5'd4;
    rw       = 5'd3;
    busw     = 32'hDEAD_BEEF;
    regWrite = 1'b1;
    applyStimulus("wr3_same_cycle", SRC_BUSA, BYPASS ? 32'hDEAD_BEEF : 32'h0000_0003);
    applyStimulus("wr3_other_port", SRC_BUSB, 32'h0000_0004);
    checkOutput();
    stepClk();
    regWrite = 1'b0;
    applyStimulus("wr3_next_cycle", SRC_BUSA, 32'hDEAD_BEEF);
    applyStimulus("wr3_narrow",     SRC_N_BUSA, 32'hF);
    checkOutput();

    // Write to address 0: discarded when hardwired, stored otherwise.
    ra       = 5'd0;
    rw       = 5'd0;
    busw     = 32'hFFFF_FFFF;
    regWrite = 1'b1;
    applyStimulus("wr0_before",   SRC_BUSA,   32'd0);
    applyStimulus("wr0_z_before", SRC_Z_BUSA, BYPASS ? 32'hFFFF_FFFF : 32'd0);
    checkOutput();
    stepClk();
    regWrite = 1'b0;
    applyStimulus("wr0_after",   SRC_BUSA,   32'd0);
    applyStimulus("wr0_z_after", SRC_Z_BUSA, 32'hFFFF_FFFF);
    checkOutput();

    // Reset in RUN with a simultaneous write to reg 9.
    ra       = 5'd9;
    rw       = 5'd9;
    busw     = 32'hAAAA_5555;
    regWrite = 1'b1;
    reset    = 1'b1;
    stepClk();
    reset    = 1'b0;
    regWrite = 1'b0;
    applyStimulus("run_reset_ready", SRC_READY, 32'd0);
    applyStimulus("run_reset_busa",  SRC_BUSA,  32'd0);
    checkOutput();

    // Run 10 sweep cycles, then reset mid-INIT for one cycle.
    for (int k = 1; k <= 10; k++) begin
      stepClk();
      applyStimulus($sformatf("partial_ready_%0d", k), SRC_READY, 32'd0);
      checkOutput();
    end
    reset = 1'b1;
    stepClk();
    reset = 1'b0;
    applyStimulus("mid_reset_ready", SRC_READY, 32'd0);
    checkOutput();
    for (int k = 1; k <= 32; k++) begin
      stepClk();
      applyStimulus($sformatf("resweep_ready_%0d", k), SRC_READY, (k == 32) ? 32'd1 : 32'd0);
      checkOutput();
    end

    // The discarded write is gone and earlier writes are overwritten by the sweep.
    ra = 5'd9;
    rb = 5'd3;
    applyStimulus("resweep_a9", SRC_BUSA, 32'h0000_0009);
    applyStimulus("resweep_b3", SRC_BUSB, 32'h0000_0003);
    checkOutput();
    ra = 5'd0;
    applyStimulus("resweep_z0", SRC_Z_BUSA, 32'h0000_0000);
    checkOutput();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/register_bank_param.md
REGISTER_BANK_PARAM -- requirements
Module: register_bank_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; depth DEPTH = 2^ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-004 Port clk, input, 1, single clock; all state changes on rising edge.
REQ-005 Port reset, input, 1, synchronous, active-high reset.
REQ-006 Port reg_write, input, 1, write enable, sampled on clk rising edge.
REQ-007 Ports ra and rb, input, ADDR_W each, read addresses for ports A and B.
REQ-008 Port rw, input, ADDR_W, write address.
REQ-009 Port busw, input, DATA_W, write data.
REQ-010 Ports busa and busb, output, DATA_W each, read data for ports A and B.
REQ-011 Port ready, output, 1, high when initialisation is complete and the bank accepts writes.

Function
REQ-012 The block SHALL implement a two-state FSM: INIT (sweeping the bank) and RUN (normal operation).
REQ-013 In INIT, an ADDR_W-bit counter SHALL write reg[cnt] = cnt (zero-extended, truncated to DATA_W) once per cycle, starting at 0, incrementing by 1.
REQ-014 When the counter reaches DEPTH-1 and writes it, the FSM SHALL enter RUN on the next edge; INIT therefore lasts exactly DEPTH cycles after reset deasserts.
REQ-015 ready SHALL be 0 in INIT and 1 in RUN.
REQ-016 In INIT, reg_write SHALL be ignored, and busa and busb SHALL read 0.
REQ-017 In RUN, when reg_write=1 at a rising edge, reg[rw] SHALL take busw, except rw=0 with ZERO_REG=1, which SHALL be discarded.
REQ-018 Reads SHALL be combinational: busa = reg[ra], busb = reg[rb]; zero latency from address change.
REQ-019 With ZERO_REG=1, reads of address 0 SHALL always return 0.
REQ-020 When ra equals rb, both ports SHALL return identical data.
REQ-021 A write SHALL become visible on the read ports in the cycle after the edge that performs it (unless REQ-026 applies).

Reset
REQ-022 reset high at a rising edge SHALL force the FSM to INIT with the counter at 0; ready SHALL be 0 from the next cycle.
REQ-023 Reset asserted mid-INIT SHALL restart the sweep from address 0.
REQ-024 Reset asserted in RUN SHALL discard any simultaneous write, and the bank contents SHALL be rewritten by the subsequent sweep.
REQ-025 While reset is held, the counter SHALL stay at 0, and no register SHALL be written other than reg[0] = 0.

Configuration
REQ-026 With macro REGFILE_BYPASS_EN defined, in RUN with reg_write=1 and rw==ra (resp. rb) and the write not discarded by REQ-017, busa (resp. busb) SHALL combinationally return busw in the same cycle.
REQ-027 Without REGFILE_BYPASS_EN, no forwarding SHALL exist, and read ports SHALL show the pre-write value until the edge.

Verification
REQ-028 Reset 1 cycle then release, DATA_W=32, ADDR_W=5 -> ready=0 for exactly 32 cycles then 1; ra=7 reads 0x00000007, ra=31 reads 0x0000001F.
REQ-029 In RUN, write rw=3, busw=0xDEADBEEF, with ra=3 -> busa=0xDEADBEEF the cycle after the edge; same cycle returns 0xDEADBEEF with REGFILE_BYPASS_EN, 0x00000003 without.
REQ-030 In RUN, write rw=0, busw=0xFFFFFFFF, ZERO_REG=1 -> ra=0 reads 0 before and after; with ZERO_REG=0 it reads 0xFFFFFFFF next cycle.
REQ-031 Assert reset at INIT cycle 10 for 1 cycle -> ready rises exactly 32 cycles after release; reg[9]=9.
REQ-032 During INIT, drive reg_write=1, rw=5, busw=0x12345678 -> ignored; after ready, ra=5 reads 0x00000005.
REQ-033 DATA_W=4, ADDR_W=5 -> after init, ra=17 reads 0x1 (truncated); ra=rb=17 -> busa==busb.
